spike_dispatch_scheduler: RTL and testbench
===========================================

# spike_dispatch_scheduler

Clocked controller that turns per-neuron spike pulses into a serialized stream of 24-bit routing packets `{source_address, downstream_address}`. It holds the neuron address table, the CSR connection-pointer table and the downstream-connection table, latches spikes into a pending vector, and arbitrates between spiking neurons. For each selected neuron it walks that neuron's CSR connection range and emits one packet per connection over a valid/ready handshake toward the accumulator fabric. It sits between the neuron adder array and the packet network.

## Interface
- `NUM_NEURONS`, 10, number of source neurons / spike inputs
- `ADDR_W`, 12, width of neuron and downstream addresses
- `MAX_CONN`, 30, downstream connection table depth
- `PTR_W`, 5, connection pointer width; must satisfy 2^PTR_W > MAX_CONN
- `CLK`  in  1  clock; all logic on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `clear`  in  1  start-of-timestep; synchronous abort and flush
- `spike_in`  in  NUM_NEURONS  spike pulses; bit i = neuron i
- `cfg_we`  in  1  configuration write strobe
- `cfg_sel`  in  2  table select: 0 = neuron address, 1 = connection pointer, 2 = downstream connection, 3 = ignored
- `cfg_index`  in  PTR_W  table entry index
- `cfg_data`  in  ADDR_W  write data; pointers use `[PTR_W-1:0]`
- `packet`  out  2*ADDR_W  `{neuron_addr[i], downstream[j]}`
- `packet_valid`  out  1  packet holds a valid packet
- `packet_ready`  in  1  downstream accepts the packet when valid && ready
- `idle`  out  1  FSM in IDLE and pending vector empty

## Operation
- Tables are registers:
  - addr[NUM_NEURONS]
  - ptr[NUM_NEURONS+1]
  - down[MAX_CONN]
- All tables reset to 0.
- Config writes:
  - Accepted only when FSM is IDLE.
  - Writes with an out-of-range index, writes with `cfg_sel`=3, and writes while not IDLE are ignored.
- Pending vector:
  - `pending <= (pending & ~grant_mask) | spike_in` every cycle.
  - A spike on a neuron already pending merges into the existing bit; it is not counted twice.
- FSM states:
  - **IDLE**: if pending ≠ 0, select neuron i (see Configuration) and clear its pending bit.
    - Load `j = ptr[i]` and `end = min(ptr[i+1], MAX_CONN)`.
    - If `j < end`, go to EMIT.
    - Otherwise stay in IDLE. This costs one cycle and emits nothing.
  - **EMIT**: drive `packet = {addr[i], down[j]}` with `packet_valid=1`.
    - On valid && ready: j ← j+1.
    - If j+1 == end, go to IDLE. Otherwise stay in EMIT.
- A neuron that re-spikes while being served is re-pended and served again in a later grant.
- `clear`:
  - pending ← 0, FSM ← IDLE, `packet_valid` ← 0.
  - Any packet in flight is dropped.
  - `spike_in` bits sampled in the same cycle as `clear` are kept as the new timestep's pending bits.
- `RESET` overrides `clear` and drops `spike_in` sampled in the same cycle.

## Timing
- Reset values:
  - `packet` = 0
  - `packet_valid` = 0
  - `idle` = 1
  - pending = 0
  - FSM = IDLE
- Latency:
  - Spike sampled at edge k → pending set after k.
  - Grant at edge k+1 → `packet_valid` high after edge k+1.
  - First packet is therefore visible one cycle after the pending bit.
- Throughput: one packet per cycle while `packet_ready`=1.
- Neuron switch overhead: one IDLE grant cycle between neurons. The valid bubble is exactly one cycle.
- Handshake:
  - `packet` and `packet_valid` are stable while valid && !ready.
  - `packet_valid` never drops without a transfer, except on `clear` or `RESET`.
- Index arithmetic is PTR_W-bit unsigned. `end` is clamped to MAX_CONN, so `down` is never read out of range.
- `ptr[i+1] ≤ ptr[i]` means zero connections.

## Configuration
- Macro `SPIKE_DISPATCH_RR_EN`:
  - **Defined**: round-robin arbitration. Search starts at (last granted + 1) mod NUM_NEURONS. The last-granted register resets to NUM_NEURONS-1, so neuron 0 is first.
  - **Undefined**: fixed priority; the lowest-index pending neuron wins.

## Test plan
- **Single spike, 3 connections.** Config: addr[2]=0x0A2, ptr[2]=4, ptr[3]=7, down[4..6]=0x101,0x102,0x103. Pulse spike_in[2] with ready=1. Expect packets 0x0A2101, 0x0A2102, 0x0A2103 on consecutive cycles, first valid 2 edges after the spike, then `idle`=1.
- **Backpressure.** Same config, ready=0 for 5 cycles after the first valid. Expect `packet`=0x0A2101 held for 5 cycles, then the remaining sequence with no loss or duplication.
- **Arbitration.** Spikes 1, 5 and 8 in the same cycle, each with 1 connection, ready=1. Expect grant order 1, 5, 8 in both builds. Then spike 1 and 8 while 5 is being served: fixed priority serves 1 before 8; with `SPIKE_DISPATCH_RR_EN`, 8 is served before 1.
- **Empty range.** ptr[3]=ptr[4]=9, spike 3. Expect no `packet_valid`, `idle`=1 two cycles later.
- **Clear mid-stream.** Assert `clear` during the 2nd packet of a 3-connection neuron, with spike_in[0] high in the same cycle. Expect valid=0 the next cycle, then neuron 0's packets only.
- **Config gating and reset.** Write down[4]=0xFFF while in EMIT; expect it ignored. Assert `RESET` mid-EMIT; expect valid=0, `idle`=1, all tables 0 the next cycle.

Source files
------------

// File: rtl/spike_dispatch_scheduler.sv
// Spike-to-packet dispatcher: latches spikes, arbitrates neurons and walks each CSR range.
// Define SPIKE_DISPATCH_RR_EN for round-robin arbitration (fixed priority otherwise).
module spike_dispatch_scheduler #(
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned MAX_CONN    = 30,
   parameter int unsigned PTR_W       = 5
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   clear,
   input  logic [NUM_NEURONS-1:0] spike_in,
   input  logic                   cfg_we,
   input  logic [1:0]             cfg_sel,
   input  logic [PTR_W-1:0]       cfg_index,
   input  logic [ADDR_W-1:0]      cfg_data,
   output logic [2*ADDR_W-1:0]    packet,
   output logic                   packet_valid,
   input  logic                   packet_ready,
   output logic                   idle
);
   localparam int unsigned NID_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int unsigned PIDX_W = $clog2(NUM_NEURONS + 1);
   localparam int unsigned DIDX_W = (MAX_CONN > 1) ? $clog2(MAX_CONN) : 1;
   localparam int unsigned PKT_W  = 2 * ADDR_W;
   localparam logic [PTR_W-1:0] MAX_CONN_P = PTR_W'(MAX_CONN);

   typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

   logic [ADDR_W-1:0] addr_tbl [NUM_NEURONS];
   logic [PTR_W-1:0]  ptr_tbl  [NUM_NEURONS+1];
   logic [ADDR_W-1:0] down_tbl [MAX_CONN];

   state_t                 state_q, state_d;
   logic [NUM_NEURONS-1:0] pending_q, pending_d, grant_mask;
   logic [NID_W-1:0]       cur_q, cur_d;
   logic [PTR_W-1:0]       j_q, j_d, end_q, end_d;
   logic [PTR_W-1:0]       g_lo, g_hi, nxt_j;
   logic [PKT_W-1:0]       packet_d;
   logic                   valid_d;
   logic                   grant;
   logic                   sel_found;
   logic [NID_W-1:0]       sel_idx;
`ifdef SPIKE_DISPATCH_RR_EN
   logic [NID_W-1:0]       last_q;
`endif

   // Configuration tables; writes only land while the walker is idle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < int'(NUM_NEURONS); k++) addr_tbl[k] <= '0;
         for (int k = 0; k < int'(NUM_NEURONS) + 1; k++) ptr_tbl[k] <= '0;
         for (int k = 0; k < int'(MAX_CONN); k++) down_tbl[k] <= '0;
      end else if (cfg_we && state_q == S_IDLE) begin
         case (cfg_sel)
            2'd0: if (32'(cfg_index) < NUM_NEURONS)
                     addr_tbl[NID_W'(cfg_index)] <= cfg_data;
            2'd1: if (32'(cfg_index) < NUM_NEURONS + 1)
                     ptr_tbl[PIDX_W'(cfg_index)] <= cfg_data[PTR_W-1:0];
            2'd2: if (32'(cfg_index) < MAX_CONN)
                     down_tbl[DIDX_W'(cfg_index)] <= cfg_data;
            default: ;
         endcase
      end
   end

   // Pending-neuron arbiter
   always_comb begin
      int unsigned idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < int'(NUM_NEURONS); k++) begin
`ifdef SPIKE_DISPATCH_RR_EN
         idx = 32'(last_q) + 32'd1 + 32'(k);
         if (idx >= NUM_NEURONS) idx = idx - NUM_NEURONS;
`else
         idx = 32'(k);
`endif
         if (!sel_found && pending_q[NID_W'(idx)]) begin
            sel_found = 1'b1;
            sel_idx   = NID_W'(idx);
         end
      end
   end

   assign grant     = (state_q == S_IDLE) && sel_found;
   assign pending_d = (pending_q & ~grant_mask) | spike_in;

   // Next state and registered-output values
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      j_d        = j_q;
      end_d      = end_q;
      packet_d   = packet;
      valid_d    = packet_valid;
      grant_mask = '0;
      g_lo       = '0;
      g_hi       = '0;
      nxt_j      = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               grant_mask[sel_idx] = 1'b1;
               cur_d = sel_idx;
               g_lo  = ptr_tbl[PIDX_W'(sel_idx)];
               g_hi  = ptr_tbl[PIDX_W'(32'(sel_idx) + 32'd1)];
               if (g_hi > MAX_CONN_P) g_hi = MAX_CONN_P;
               j_d   = g_lo;
               end_d = g_hi;
               if (g_lo < g_hi) begin
                  state_d  = S_EMIT;
                  valid_d  = 1'b1;
                  packet_d = {addr_tbl[sel_idx], down_tbl[DIDX_W'(g_lo)]};
               end
            end
         end
         S_EMIT: begin
            if (packet_ready) begin
               nxt_j = PTR_W'(j_q + 1'b1);
               j_d   = nxt_j;
               if (nxt_j == end_q) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
               end else begin
                  packet_d = {addr_tbl[cur_q], down_tbl[DIDX_W'(nxt_j)]};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; clear keeps same-cycle spikes as the new pending set
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         cur_q        <= '0;
         j_q          <= '0;
         end_q        <= '0;
         packet       <= '0;
         packet_valid <= 1'b0;
         idle         <= 1'b1;
`ifdef SPIKE_DISPATCH_RR_EN
         last_q       <= NID_W'(NUM_NEURONS - 1);
`endif
      end else if (clear) begin
         state_q      <= S_IDLE;
         pending_q    <= spike_in;
         packet_valid <= 1'b0;
         idle         <= (spike_in == '0);
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         cur_q        <= cur_d;
         j_q          <= j_d;
         end_q        <= end_d;
         packet       <= packet_d;
         packet_valid <= valid_d;
         idle         <= (state_d == S_IDLE) && (pending_d == '0);
`ifdef SPIKE_DISPATCH_RR_EN
         if (grant) last_q <= sel_idx;
`endif
      end
   end

`ifndef SPIKE_DISPATCH_RR_EN
   logic unused_grant;
   assign unused_grant = grant;
`endif

endmodule

// File: tb/tb_spike_dispatch_scheduler.sv
// Directed bench for spike_dispatch_scheduler: reset, streaming, backpressure,
// arbitration, clear, empty range, config gating and reset mid-stream.
module tb_spike_dispatch_scheduler;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        clear;
   logic [9:0]  spike_in;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [4:0]  cfg_index;
   logic [11:0] cfg_data;
   logic [23:0] packet;
   logic        packet_valid;
   logic        packet_ready;
   logic        idle;

   int errors = 0;
   int checks = 0;

   int unsigned ptr_init  [11] = '{0, 3, 4, 7, 7, 7, 8, 8, 8, 9, 9};
   logic [11:0] down_init [9]  = '{12'h201, 12'h202, 12'h203, 12'h301, 12'h101,
                                   12'h102, 12'h103, 12'h305, 12'h308};

`ifdef SPIKE_DISPATCH_RR_EN
   localparam logic [31:0] ARB_A = 32'h0A8308;
   localparam logic [31:0] ARB_B = 32'h0A1301;
`else
   localparam logic [31:0] ARB_A = 32'h0A1301;
   localparam logic [31:0] ARB_B = 32'h0A8308;
`endif

   spike_dispatch_scheduler dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .clear        (clear),
      .spike_in     (spike_in),
      .cfg_we       (cfg_we),
      .cfg_sel      (cfg_sel),
      .cfg_index    (cfg_index),
      .cfg_data     (cfg_data),
      .packet       (packet),
      .packet_valid (packet_valid),
      .packet_ready (packet_ready),
      .idle         (idle)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] sel, input int idx, input logic [11:0] data);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_index = 5'(idx);
      cfg_data  = data;
      tick();
      cfg_we    = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; clear = 1'b0; spike_in = '0; cfg_we = 1'b0;
      cfg_sel = '0; cfg_index = '0; cfg_data = '0; packet_ready = 1'b1;
      tick(); tick();
      chk("rst_packet", 32'(packet), 32'h0);
      chk("rst_valid", 32'(packet_valid), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      RESET = 1'b0;

      cfg(2'd0, 0, 12'h0A0); cfg(2'd0, 1, 12'h0A1); cfg(2'd0, 2, 12'h0A2);
      cfg(2'd0, 5, 12'h0A5); cfg(2'd0, 8, 12'h0A8);
      for (int k = 1; k < 11; k++) cfg(2'd1, k, 12'(ptr_init[k]));
      for (int k = 0; k < 9; k++) cfg(2'd2, k, down_init[k]);
      chk("cfg_idle", 32'(idle), 32'h1);

      // arbitration: 1, 5, 8 together; then 1 and 8 while 5 is served
      spike_in = 10'b01_0010_0010; tick(); spike_in = '0;
      tick(); chk("arb_first", 32'(packet), 32'h0A1301);
      chk("arb_first_v", 32'(packet_valid), 32'h1);
      tick(); chk("arb_bubble", 32'(packet_valid), 32'h0);
      tick(); chk("arb_second", 32'(packet), 32'h0A5305);
      spike_in = 10'b01_0000_0010; tick(); spike_in = '0;
      chk("arb_bubble2", 32'(packet_valid), 32'h0);
      tick(); chk("arb_third", 32'(packet), ARB_A);
      tick(); chk("arb_bubble3", 32'(packet_valid), 32'h0);
      tick(); chk("arb_fourth", 32'(packet), ARB_B);
      tick(); chk("arb_done_idle", 32'(idle), 32'h1);

      // single spike, 3 connections
      spike_in = 10'b00_0000_0100; tick(); spike_in = '0;
      chk("s1_valid_k", 32'(packet_valid), 32'h0);
      chk("s1_idle_k", 32'(idle), 32'h0);
      tick(); chk("s1_pkt0", 32'(packet), 32'h0A2101);
      chk("s1_valid0", 32'(packet_valid), 32'h1);
      tick(); chk("s1_pkt1", 32'(packet), 32'h0A2102);
      tick(); chk("s1_pkt2", 32'(packet), 32'h0A2103);
      chk("s1_valid2", 32'(packet_valid), 32'h1);
      tick(); chk("s1_end_valid", 32'(packet_valid), 32'h0);
      chk("s1_end_idle", 32'(idle), 32'h1);

      // backpressure, with a config write attempted during EMIT
      packet_ready = 1'b0;
      spike_in = 10'b00_0000_0100; tick(); spike_in = '0;
      tick(); chk("bp_hold1", 32'(packet), 32'h0A2101);
      tick(); chk("bp_hold2", 32'(packet), 32'h0A2101);
      cfg(2'd2, 4, 12'hFFF);
      chk("bp_hold3", 32'(packet), 32'h0A2101);
      tick(); chk("bp_hold4", 32'(packet), 32'h0A2101);
      tick(); chk("bp_hold5", 32'(packet), 32'h0A2101);
      chk("bp_hold5_v", 32'(packet_valid), 32'h1);
      packet_ready = 1'b1;
      tick(); chk("bp_pkt1", 32'(packet), 32'h0A2102);
      tick(); chk("bp_pkt2", 32'(packet), 32'h0A2103);
      tick(); chk("bp_end_valid", 32'(packet_valid), 32'h0);

      // the gated write must not have altered down[4]
      spike_in = 10'b00_0000_0100; tick(); spike_in = '0;
      tick(); chk("gate_pkt0", 32'(packet), 32'h0A2101);
      tick(); tick(); tick();
      chk("gate_idle", 32'(idle), 32'h1);

      // clear during the second packet with spike 0 in the same cycle
      spike_in = 10'b00_0000_0100; tick(); spike_in = '0;
      tick(); tick(); chk("clr_pre", 32'(packet), 32'h0A2102);
      clear = 1'b1; spike_in = 10'b00_0000_0001; tick();
      clear = 1'b0; spike_in = '0;
      chk("clr_valid", 32'(packet_valid), 32'h0);
      chk("clr_idle", 32'(idle), 32'h0);
      tick(); chk("clr_n0_pkt0", 32'(packet), 32'h0A0201);
      tick(); chk("clr_n0_pkt1", 32'(packet), 32'h0A0202);
      tick(); chk("clr_n0_pkt2", 32'(packet), 32'h0A0203);
      tick(); chk("clr_end_valid", 32'(packet_valid), 32'h0);
      chk("clr_end_idle", 32'(idle), 32'h1);

      // empty connection range
      cfg(2'd1, 3, 12'd9); cfg(2'd1, 4, 12'd9);
      spike_in = 10'b00_0000_1000; tick(); spike_in = '0;
      chk("empty_valid_k", 32'(packet_valid), 32'h0);
      tick(); chk("empty_valid", 32'(packet_valid), 32'h0);
      chk("empty_idle", 32'(idle), 32'h1);

      // reset mid-EMIT, spike in the same cycle is dropped
      spike_in = 10'b00_0000_0001; tick(); spike_in = '0;
      tick(); tick(); chk("rst2_pre", 32'(packet), 32'h0A0202);
      RESET = 1'b1; spike_in = 10'b00_0000_0001; tick();
      RESET = 1'b0; spike_in = '0;
      chk("rst2_valid", 32'(packet_valid), 32'h0);
      chk("rst2_idle", 32'(idle), 32'h1);
      chk("rst2_packet", 32'(packet), 32'h0);
      chk("rst2_down4", 32'(dut.down_tbl[4]), 32'h0);
      chk("rst2_addr0", 32'(dut.addr_tbl[0]), 32'h0);
      tick(); chk("rst2_no_pend", 32'(idle), 32'h1);
      spike_in = 10'b00_0000_0001; tick(); spike_in = '0;
      tick(); chk("rst2_ptr_zero_v", 32'(packet_valid), 32'h0);
      chk("rst2_ptr_zero_idle", 32'(idle), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
